// File: rtl/prod_arbiter_if.sv
// Producer-side bus of prod_arbiter: control pulses, the two producer
// handshakes, buffer status and the buffer write port.
//
// Handshake: a producer raises *_valid with *_data and holds both stable
// until the arbiter answers with a one-cycle *_ack in the same cycle as the
// grant. The buffer write side has no ready: wr_en is a one-cycle strobe,
// and buffer_full is back-pressure that stops further grants.
interface prod_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              start_f;
  logic              start_t;
  logic              stop;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;
  logic              t_valid;
  logic [DATA_W-1:0] t_data;
  logic              buffer_full;
  logic              buffer_empty;
  logic              data_valid_2;
  logic              f_en;
  logic              t_en;
  logic              f_ack;
  logic              t_ack;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_src;
  logic [1:0]        state;

  // Environment side: buttons, producers and buffer wrapper
  modport master (
    output start_f, start_t, stop, f_valid, f_data, t_valid, t_data,
           buffer_full, buffer_empty, data_valid_2,
    input  f_en, t_en, f_ack, t_ack, wr_en, wr_data, wr_src, state
  );

  // Arbiter side
  modport slave (
    input  start_f, start_t, stop, f_valid, f_data, t_valid, t_data,
           buffer_full, buffer_empty, data_valid_2,
    output f_en, t_en, f_ack, t_ack, wr_en, wr_data, wr_src, state
  );
endinterface

// File: rtl/prod_arbiter.sv
// prod_arbiter: start/stop sequencing and write-port sharing between the
// Fibonacci and Timer producers, in the producer clock domain.
// States IDLE/RUN/WAIT_FULL/DRAIN are exported on bus.state.
// Optional build macro FIXED_PRIO_EN: Fibonacci always wins a contended
// grant; otherwise round-robin with a BURST_MAX consecutive-grant limit.
module prod_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  prod_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    WAIT_FULL = 2'b10,
    DRAIN     = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              en_f_q, en_f_d;
  logic              en_t_q, en_t_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_src_q, wr_src_d;

  logic grant_ok;
  logic cand_f, cand_t;
  logic pick_f;
  logic grant_f, grant_t;

  // A grant needs a free cycle after the previous write, so full never overruns
  assign grant_ok = (state_q == RUN) & ~bus.buffer_full & ~wr_en_q & ~bus.stop;
  assign cand_f   = bus.f_valid & en_f_q;
  assign cand_t   = bus.t_valid & en_t_q;
  assign grant_f  = grant_ok & cand_f & pick_f;
  assign grant_t  = grant_ok & cand_t & ~pick_f;

`ifdef FIXED_PRIO_EN
  // Fibonacci wins whenever it is a candidate
  assign pick_f = cand_f;
`else
  logic       last_f_q, last_f_d;   // 1 = Fibonacci granted last, 0 = Timer
  logic [3:0] burst_q, burst_d;
  logic       other_req;

  // Round-robin choice and burst bookkeeping for the next grant
  always_comb begin
    pick_f    = cand_f;
    last_f_d  = last_f_q;
    burst_d   = burst_q;
    other_req = 1'b0;
    // Contended: the source not granted last wins. Rotation hands over after
    // every contended grant, so a run never reaches BURST_MAX under contention.
    if (cand_f && cand_t) begin
      pick_f = ~last_f_q;
    end
    if (grant_f || grant_t) begin
      last_f_d  = grant_f;
      other_req = grant_f ? cand_t : cand_f;
      if (!other_req) begin
        burst_d = 4'd0;
      end else if (grant_f != last_f_q) begin
        burst_d = 4'd1;
      end else if (burst_q < 4'(BURST_MAX)) begin
        burst_d = burst_q + 4'd1;
      end
    end
  end

  // Last-winner and burst registers; reset makes Timer the last winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_f_q <= 1'b0;
      burst_q  <= 4'd0;
    end else begin
      last_f_q <= last_f_d;
      burst_q  <= burst_d;
    end
  end
`endif

  // Next state and source enables
  always_comb begin
    state_d = state_q;
    en_f_d  = en_f_q;
    en_t_d  = en_t_q;
    case (state_q)
      IDLE: begin
        if (bus.start_f) en_f_d = 1'b1;
        if (bus.start_t) en_t_d = 1'b1;
        if (bus.start_f || bus.start_t) state_d = RUN;
      end
      RUN: begin
        if (bus.stop) begin
          state_d = DRAIN;
        end else begin
          if (bus.start_f) en_f_d = 1'b1;
          if (bus.start_t) en_t_d = 1'b1;
          if (bus.buffer_full) state_d = WAIT_FULL;
        end
      end
      WAIT_FULL: begin
        if (bus.stop) begin
          state_d = DRAIN;
        end else if (!bus.buffer_full) begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (bus.buffer_empty && !bus.data_valid_2 && !wr_en_q) begin
          state_d = IDLE;
          en_f_d  = 1'b0;
          en_t_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port: one-cycle strobe after each grant, data held between writes
  always_comb begin
    wr_en_d   = grant_f | grant_t;
    wr_src_d  = {grant_t, grant_f};
    wr_data_d = wr_data_q;
    if (grant_f) begin
      wr_data_d = bus.f_data;
    end else if (grant_t) begin
      wr_data_d = bus.t_data;
    end
  end

  // State, enable and write registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      en_f_q    <= 1'b0;
      en_t_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_src_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      en_f_q    <= en_f_d;
      en_t_q    <= en_t_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign bus.f_en    = (state_q == RUN) & en_f_q & ~bus.buffer_full;
  assign bus.t_en    = (state_q == RUN) & en_t_q & ~bus.buffer_full;
  assign bus.f_ack   = grant_f;
  assign bus.t_ack   = grant_t;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_src  = wr_src_q;
  assign bus.state   = state_q;

endmodule
